booth_radix4_seq_multiplier: RTL and testbench

- Iterative, parametrised radix-4 (modified) Booth multiplier. Retires two multiplier bits per clock.
- Selects signed or unsigned operands per transaction.
- Valid/ready handshake on input and output, so it sits behind a register file or a streaming datapath as a multi-cycle arithmetic unit.
- Successor to the combinational radix-2 Booth multiplier: trades area for latency and adds mode select and flow control.

---
 rtl/booth_radix4_seq_multiplier_if.sv | 25 ++
 rtl/booth_radix4_seq_multiplier.sv | 112 +++++++++++
 tb/tb_booth_radix4_seq_multiplier.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_radix4_seq_multiplier_if.sv
// Handshake bundle for the sequential radix-4 Booth multiplier.
// Master drives operands and out_ready; slave returns the product.
interface booth_radix4_seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               signed_mode;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    modport master (
        output in_valid, multiplicand, multiplier, signed_mode, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, signed_mode, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_radix4_seq_multiplier.sv
// Iterative radix-4 Booth multiplier, two multiplier bits per clock.
// Signed or unsigned operands per transaction, valid/ready on both sides.
module booth_radix4_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic rst,
    booth_radix4_seq_multiplier_if.slave bus
);
    localparam int ITER = WIDTH / 2 + 1;
    localparam int EW   = WIDTH + 2;
    localparam int AW   = 2 * WIDTH + 4;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [EW:0] ONE = (EW + 1)'(1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [EW-1:0]      mcand;
    logic [EW:0]        mreg;
    logic [AW-1:0]      acc;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] product_q;
    logic               out_valid_q;
    logic               in_ready_q;
    logic               busy_q;

    logic [EW-1:0]      a_ext;
    logic [EW-1:0]      b_ext;
    logic [EW:0]        m1;
    logic [EW:0]        m2;
    logic [EW:0]        pp;
    logic [EW:0]        hi_sum;
    logic signed [AW:0] wide;
    logic [AW-1:0]      acc_next;

    assign a_ext = bus.signed_mode ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                   : {2'b00, bus.multiplicand};
    assign b_ext = bus.signed_mode ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                   : {2'b00, bus.multiplier};

    assign m1 = {mcand[EW-1], mcand};
    assign m2 = {mcand, 1'b0};

    always_comb begin
        pp = '0;
        unique case (mreg[2:0])
            3'b001, 3'b010: pp = m1;
            3'b011:         pp = m2;
            3'b100:         pp = ~m2 + ONE;
            3'b101, 3'b110: pp = ~m1 + ONE;
            default:        pp = '0;
        endcase
    end

    // One guard bit on the upper sum so a +-2M step cannot wrap before the shift.
    assign hi_sum   = {acc[AW-1], acc[AW-1 -: EW]} + pp;
    assign wide     = $signed({hi_sum, acc[EW-1:0]});
    assign acc_next = AW'(wide >>> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            mcand       <= '0;
            mreg        <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand      <= a_ext;
                        mreg       <= {b_ext, 1'b0};
                        acc        <= '0;
                        cnt        <= '0;
                        state      <= CALC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                CALC: begin
                    acc  <= acc_next;
                    mreg <= mreg >> 2;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        product_q   <= acc_next[2*WIDTH-1:0];
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_booth_radix4_seq_multiplier.sv
// Randomised self-checking bench for the radix-4 Booth multiplier.
// Products are compared against plain wide-integer multiplication.
module tb_booth_radix4_seq_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    booth_radix4_seq_multiplier_if #(.WIDTH(32)) i32 ();
    booth_radix4_seq_multiplier_if #(.WIDTH(8))  i8 ();

    booth_radix4_seq_multiplier #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .bus(i32)
    );
    booth_radix4_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .bus(i8)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [63:0] ref32(logic [31:0] a, logic [31:0] b, logic s);
        logic [63:0] x, y;
        x = s ? {{32{a[31]}}, a} : {32'b0, a};
        y = s ? {{32{b[31]}}, b} : {32'b0, b};
        return x * y;
    endfunction

    function automatic logic [15:0] ref8(logic [7:0] a, logic [7:0] b, logic s);
        logic [15:0] x, y;
        x = s ? {{8{a[7]}}, a} : {8'b0, a};
        y = s ? {{8{b[7]}}, b} : {8'b0, b};
        return x * y;
    endfunction

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [63:0] p, output int lat);
        int n;
        n = 0;
        while (!i32.in_ready && n < 200) begin @(posedge clk); #1; n++; end
        i32.in_valid = 1'b1;
        i32.multiplicand = a;
        i32.multiplier = b;
        i32.signed_mode = s;
        @(posedge clk); #1;
        i32.in_valid = 1'b0;
        lat = 0;
        while (!i32.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        p = i32.product;
        i32.out_ready = 1'b1;
        @(posedge clk); #1;
        i32.out_ready = 1'b0;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output logic [15:0] p, output int lat);
        int n;
        n = 0;
        while (!i8.in_ready && n < 200) begin @(posedge clk); #1; n++; end
        i8.in_valid = 1'b1;
        i8.multiplicand = a;
        i8.multiplier = b;
        i8.signed_mode = s;
        @(posedge clk); #1;
        i8.in_valid = 1'b0;
        lat = 0;
        while (!i8.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        p = i8.product;
        i8.out_ready = 1'b1;
        @(posedge clk); #1;
        i8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        i32.in_valid = 0; i32.out_ready = 0; i32.signed_mode = 0;
        i32.multiplicand = 0; i32.multiplier = 0;
        i8.in_valid = 0; i8.out_ready = 0; i8.signed_mode = 0;
        i8.multiplicand = 0; i8.multiplier = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (i32.in_ready !== 1'b1 || i32.out_valid !== 1'b0 || i32.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b vld=%b busy=%b want 1 0 0",
                     i32.in_ready, i32.out_valid, i32.busy);
        end
        checks++;
        if (i32.product !== 64'd0) begin
            errors++;
            $display("FAIL reset_product got %h want 0", i32.product);
        end
        checks++;
        if (i8.in_ready !== 1'b1 || i8.out_valid !== 1'b0 || i8.product !== 16'd0) begin
            errors++;
            $display("FAIL reset_w8 got rdy=%b vld=%b p=%h", i8.in_ready, i8.out_valid, i8.product);
        end
    endtask

    task automatic test_signed();
        logic [63:0] p;
        int lat;
        op32(32'hFFFF_FFF9, 32'd3, 1'b1, p, lat);
        checks++;
        if (p !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++;
            $display("FAIL signed_m7x3 got %h want ffffffffffffffeb", p);
        end
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL latency32 got %0d want 17", lat);
        end
    endtask

    task automatic test_extremes();
        logic [31:0] ta [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] tb [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        logic        ts [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [63:0] te [4] = '{64'hFFFF_FFFE_0000_0001, 64'h4000_0000_0000_0000,
                                64'h0000_0000_8000_0000, 64'hC000_0000_8000_0000};
        logic [63:0] p;
        int lat;
        for (int i = 0; i < 4; i++) begin
            op32(ta[i], tb[i], ts[i], p, lat);
            checks++;
            if (p !== te[i]) begin
                errors++;
                $display("FAIL extreme_%0d got %h want %h", i, p, te[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp, p;
        int n, lat;
        exp = ref32(32'h0000_1234, 32'h0000_ABCD, 1'b0);
        i32.in_valid = 1'b1;
        i32.multiplicand = 32'h0000_1234;
        i32.multiplier = 32'h0000_ABCD;
        i32.signed_mode = 1'b0;
        @(posedge clk); #1;
        i32.in_valid = 1'b0;
        n = 0;
        while (!i32.out_valid && n < 200) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i32.out_valid !== 1'b1 || i32.product !== exp ||
                i32.in_ready !== 1'b0 || i32.busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_%0d got vld=%b rdy=%b busy=%b p=%h want 1 0 1 %h",
                         i, i32.out_valid, i32.in_ready, i32.busy, i32.product, exp);
            end
            i32.in_valid = (i == 3);
            i32.multiplicand = 32'd5;
            i32.multiplier = 32'd5;
            @(posedge clk); #1;
        end
        i32.in_valid = 1'b0;
        i32.out_ready = 1'b1;
        @(posedge clk); #1;
        i32.out_ready = 1'b0;
        checks++;
        if (i32.in_ready !== 1'b1 || i32.out_valid !== 1'b0 || i32.product !== exp) begin
            errors++;
            $display("FAIL release got rdy=%b vld=%b p=%h want 1 0 %h",
                     i32.in_ready, i32.out_valid, i32.product, exp);
        end
        op32(32'd5, 32'd5, 1'b0, p, lat);
        checks++;
        if (p !== 64'd25) begin
            errors++;
            $display("FAIL after_hold_5x5 got %h want 25", p);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] p;
        int lat;
        i32.in_valid = 1'b1;
        i32.multiplicand = 32'd12345;
        i32.multiplier = 32'd678;
        i32.signed_mode = 1'b1;
        @(posedge clk); #1;
        i32.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (i32.in_ready !== 1'b1 || i32.out_valid !== 1'b0 ||
            i32.product !== 64'd0 || i32.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got rdy=%b vld=%b busy=%b p=%h want 1 0 0 0",
                     i32.in_ready, i32.out_valid, i32.busy, i32.product);
        end
        op32(32'd12, 32'hFFFF_FFF4, 1'b1, p, lat);
        checks++;
        if (p !== 64'hFFFF_FFFF_FFFF_FF70 || lat !== 17) begin
            errors++;
            $display("FAIL post_reset_12xm12 got %h lat %0d want ffffffffffffff70 lat 17", p, lat);
        end
    endtask

    task automatic test_width8();
        logic [7:0] cv [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        logic [15:0] p, exp;
        logic [7:0] a, b;
        logic s;
        int lat, bad, badlat;
        bad = 0;
        badlat = 0;
        for (int k = 0; k < 350; k++) begin
            if (k < 50) begin
                a = cv[k % 5];
                b = cv[(k / 5) % 5];
                s = (k >= 25);
            end else begin
                a = 8'($urandom);
                b = 8'($urandom);
                s = 1'($urandom_range(0, 1));
            end
            exp = ref8(a, b, s);
            op8(a, b, s, p, lat);
            checks++;
            if (p !== exp || lat !== 5) begin
                errors++;
                if (bad < 5)
                    $display("FAIL w8 a=%h b=%h s=%b got %h lat %0d want %h lat 5",
                             a, b, s, p, lat, exp);
                bad++;
            end
        end
    endtask

    task automatic test_stream();
        localparam int N = 300;
        logic [63:0] q[$];
        int got;
        got = 0;
        fork
            begin : producer
                logic [31:0] a, b;
                logic s;
                int wt;
                for (int k = 0; k < N; k++) begin
                    a = $urandom;
                    b = $urandom;
                    s = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
                    i32.in_valid = 1'b1;
                    i32.multiplicand = a;
                    i32.multiplier = b;
                    i32.signed_mode = s;
                    wt = 0;
                    while (!i32.in_ready && wt < 100) begin @(posedge clk); #1; wt++; end
                    @(posedge clk); #1;
                    i32.in_valid = 1'b0;
                    q.push_back(ref32(a, b, s));
                    if (wt >= 100) begin
                        checks++;
                        errors++;
                        $display("FAIL stream_accept_timeout k=%0d got stalled want accept", k);
                    end
                end
            end
            begin : consumer
                logic [63:0] exp;
                int cyc;
                cyc = 0;
                while (got < N && cyc < N * 60) begin
                    @(posedge clk); #1;
                    cyc++;
                    i32.out_ready = 1'($urandom_range(0, 1));
                    if (i32.out_valid && i32.out_ready) begin
                        exp = (q.size() > 0) ? q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
                        checks++;
                        if (i32.product !== exp) begin
                            errors++;
                            $display("FAIL stream_%0d got %h want %h", got, i32.product, exp);
                        end
                        got++;
                    end
                end
                @(posedge clk); #1;
                i32.out_ready = 1'b0;
            end
        join
        checks++;
        if (got !== N || q.size() !== 0) begin
            errors++;
            $display("FAIL stream_count got %0d left %0d want %0d left 0", got, q.size(), N);
        end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        test_width8();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
